// File: rtl/core_ctrl_fsm_if.sv
`default_nettype none
// ============================================================================
//  Module      : core_ctrl_fsm_if
//  Description : Data-memory request/acknowledge handshake between the core
//                control unit (master) and the data memory (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
interface core_ctrl_fsm_if;
    logic dmem_req;   // access request, held until acknowledged
    logic dmem_we;    // 1 store, 0 load; meaningful while dmem_req=1
    logic dmem_ack;   // access complete; read data valid this cycle

    modport master (
        output dmem_req,
        output dmem_we,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        output dmem_ack
    );
endinterface
`default_nettype wire

// File: rtl/core_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : core_ctrl_fsm
//  Description : RV32I sequencing control unit. Decodes the current
//                instruction into datapath controls, stalls the PC around
//                variable-latency data-memory accesses, counts retired
//                instructions and halts on illegal encodings.
//                Optional feature macro: DMEM_TIMEOUT_EN (bounds the memory
//                wait to TIMEOUT_CYC cycles, then raises bus_err and halts).
//  Revision    : 1.0 - initial release
// ============================================================================
module core_ctrl_fsm #(
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 16
) (
    input  wire               clk,
    input  wire               rst,          // synchronous, active-low
    input  wire  [31:0]       instr_i,
    input  wire               zero_i,
    core_ctrl_fsm_if.master   dmem,
    output logic              pc_en_o,
    output logic [1:0]        PCsrc_o,
    output logic [1:0]        immsrc_o,
    output logic              ALUsrc_o,
    output logic [1:0]        ALUctrl_o,
    output logic [1:0]        resultsrc_o,
    output logic              regwr_o,
    output logic              halted_o,
    output logic              bus_err_o,
    output logic [CNT_W-1:0]  retire_cnt_o
);

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LW     = 7'b0000011;
    localparam logic [6:0] OPC_SW     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_OR  = 2'b11;

    typedef enum logic [1:0] {
        S_EXEC = 2'd0,
        S_MEM  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] retire_cnt_q;
    logic             halted_q;

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_legal, w_is_lw, w_is_sw;
    logic       w_regwr_dec, w_alusrc, w_alu_ok, w_br_taken;
    logic [1:0] w_immsrc, w_aluctrl, w_resultsrc, w_pcsrc, w_alu_op;
    logic       w_pc_en, w_regwr, w_req, w_we, w_retire;
    logic       w_to_hit;

    assign w_opcode = instr_i[6:0];
    assign w_funct3 = instr_i[14:12];

    // Register/immediate fields are consumed by the datapath, not here.
    logic unused_instr_bits;
    assign unused_instr_bits = &{1'b0, instr_i[31], instr_i[29:15], instr_i[11:7]};

    // Instruction decode: datapath selects plus legality classification
    always_comb begin
        w_legal     = 1'b0;
        w_is_lw     = 1'b0;
        w_is_sw     = 1'b0;
        w_regwr_dec = 1'b0;
        w_immsrc    = 2'b00;
        w_alusrc    = 1'b0;
        w_aluctrl   = ALU_ADD;
        w_resultsrc = 2'b00;
        w_pcsrc     = 2'b00;
        w_alu_ok    = 1'b0;
        w_alu_op    = ALU_ADD;
        w_br_taken  = 1'b0;

        // funct3 -> ALU op, shared by R-type and I-ALU
        case (w_funct3)
            3'b000: begin
                w_alu_ok = 1'b1;
                w_alu_op = (w_opcode == OPC_RTYPE && instr_i[30]) ? ALU_SUB : ALU_ADD;
            end
            3'b111: begin
                w_alu_ok = 1'b1;
                w_alu_op = ALU_AND;
            end
            3'b110: begin
                w_alu_ok = 1'b1;
                w_alu_op = ALU_OR;
            end
            default: ;
        endcase

        case (w_opcode)
            OPC_RTYPE: begin
                w_legal     = w_alu_ok;
                w_regwr_dec = 1'b1;
                w_aluctrl   = w_alu_op;
            end
            OPC_IALU: begin
                w_legal     = w_alu_ok;
                w_regwr_dec = 1'b1;
                w_alusrc    = 1'b1;
                w_aluctrl   = w_alu_op;
            end
            OPC_LW: begin
                w_legal     = 1'b1;
                w_is_lw     = 1'b1;
                w_alusrc    = 1'b1;
                w_resultsrc = 2'b01;
            end
            OPC_SW: begin
                w_legal  = 1'b1;
                w_is_sw  = 1'b1;
                w_immsrc = 2'b01;
                w_alusrc = 1'b1;
            end
            OPC_BRANCH: begin
                w_immsrc  = 2'b10;
                w_aluctrl = ALU_SUB;
                if (w_funct3 == 3'b000) begin
                    w_legal    = 1'b1;
                    w_br_taken = zero_i;
                end else if (w_funct3 == 3'b001) begin
                    w_legal    = 1'b1;
                    w_br_taken = ~zero_i;
                end
                w_pcsrc = w_br_taken ? 2'b01 : 2'b00;
            end
            OPC_JAL: begin
                w_legal     = 1'b1;
                w_regwr_dec = 1'b1;
                w_immsrc    = 2'b11;
                w_resultsrc = 2'b10;
                w_pcsrc     = 2'b01;
            end
            OPC_JALR: begin
                w_legal     = 1'b1;
                w_regwr_dec = 1'b1;
                w_alusrc    = 1'b1;
                w_resultsrc = 2'b10;
                w_pcsrc     = 2'b10;
            end
            default: ;
        endcase
    end

    // Next-state logic and sequencing strobes
    always_comb begin
        state_d  = state_q;
        w_pc_en  = 1'b0;
        w_regwr  = 1'b0;
        w_req    = 1'b0;
        w_we     = 1'b0;
        w_retire = 1'b0;

        case (state_q)
            S_EXEC: begin
                if (!w_legal) begin
                    state_d = S_HALT;
                end else if (w_is_lw || w_is_sw) begin
                    state_d = S_MEM;
                end else begin
                    w_pc_en  = 1'b1;
                    w_regwr  = w_regwr_dec;
                    w_retire = 1'b1;
                end
            end
            S_MEM: begin
                // PC is frozen here, so instr_i (and its decode) stays stable
                w_req = 1'b1;
                w_we  = w_is_sw;
                if (dmem.dmem_ack) begin
                    w_pc_en  = 1'b1;
                    w_regwr  = w_is_lw;
                    w_retire = 1'b1;
                    state_d  = S_EXEC;
                end else if (w_to_hit) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: ;
            default: state_d = S_HALT;
        endcase
    end

    // Output stage: reset forces strobes and mux selects low
    always_comb begin
        pc_en_o       = 1'b0;
        regwr_o       = 1'b0;
        dmem.dmem_req = 1'b0;
        dmem.dmem_we  = 1'b0;
        PCsrc_o       = 2'b00;
        immsrc_o      = 2'b00;
        ALUsrc_o      = 1'b0;
        ALUctrl_o     = 2'b00;
        resultsrc_o   = 2'b00;
        if (rst) begin
            pc_en_o       = w_pc_en;
            regwr_o       = w_regwr;
            dmem.dmem_req = w_req;
            dmem.dmem_we  = w_we;
            PCsrc_o       = w_pcsrc;
            immsrc_o      = w_immsrc;
            ALUsrc_o      = w_alusrc;
            ALUctrl_o     = w_aluctrl;
            resultsrc_o   = w_resultsrc;
        end
    end

    // State register, retire counter and sticky halt flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_EXEC;
            retire_cnt_q <= '0;
            halted_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (w_retire) begin
                retire_cnt_q <= retire_cnt_q + CNT_W'(1);
            end
            if (state_d == S_HALT) begin
                halted_q <= 1'b1;
            end
        end
    end

`ifdef DMEM_TIMEOUT_EN
    localparam int             TO_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt_q;
    logic            bus_err_q;

    // Last permitted wait cycle still without ack: give up on the access
    assign w_to_hit = (state_q == S_MEM) && !dmem.dmem_ack && (to_cnt_q == TO_LAST);

    // Wait-cycle counter (held at zero outside MEM) and sticky bus error
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q  <= '0;
            bus_err_q <= 1'b0;
        end else begin
            if (state_q != S_MEM) begin
                to_cnt_q <= '0;
            end else if (!dmem.dmem_ack && !w_to_hit) begin
                to_cnt_q <= to_cnt_q + TO_W'(1);
            end
            if (w_to_hit) begin
                bus_err_q <= 1'b1;
            end
        end
    end

    assign bus_err_o = bus_err_q;
`else
    // Without the timeout the memory wait is unbounded.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign w_to_hit  = 1'b0;
    assign bus_err_o = 1'b0;
`endif

    assign halted_o     = halted_q;
    assign retire_cnt_o = retire_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_core_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_core_ctrl_fsm
//  Description : Self-checking bench for core_ctrl_fsm. Directed scenarios
//                followed by randomized instruction/ack/zero/reset stimulus,
//                all compared cycle by cycle against an instruction-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_ctrl_fsm;

    localparam int TB_CNT_W = 6;    // small so the retire counter wraps
    localparam int TB_TO    = 4;
    localparam int CNT_MOD  = 1 << TB_CNT_W;

    localparam logic [12:0] M_PCEN = 13'h1000;
    localparam logic [12:0] M_RW   = 13'h0800;
    localparam logic [12:0] M_REQ  = 13'h0400;
    localparam logic [12:0] M_WE   = 13'h0200;
    localparam logic [12:0] M_PCS  = 13'h0180;
    localparam logic [12:0] M_IMM  = 13'h0060;
    localparam logic [12:0] M_ALUS = 13'h0010;
    localparam logic [12:0] M_ALUC = 13'h000C;
    localparam logic [12:0] M_RES  = 13'h0003;

    localparam logic [31:0] I_ADDI = 32'h00500093;  // addi x1,x0,5
    localparam logic [31:0] I_LW   = 32'h0000A103;  // lw   x2,0(x1)
    localparam logic [31:0] I_SW   = 32'h0020A223;  // sw   x2,4(x1)
    localparam logic [31:0] I_BEQ  = 32'h00108463;  // beq  x1,x1,+8
    localparam logic [31:0] I_JALR = 32'h000280E7;  // jalr x1,0(x5)
    localparam logic [31:0] I_BAD  = 32'h0000007F;

    typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_JAL, K_JALR, K_ILL} kind_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [31:0]         instr;
    logic                zero;
    logic                pc_en, ALUsrc, regwr, halted, bus_err;
    logic [1:0]          PCsrc, immsrc, ALUctrl, resultsrc;
    logic [TB_CNT_W-1:0] retire_cnt;

    core_ctrl_fsm_if dmem_bus ();

    core_ctrl_fsm #(
        .CNT_W       (TB_CNT_W),
        .TIMEOUT_CYC (TB_TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .instr_i      (instr),
        .zero_i       (zero),
        .dmem         (dmem_bus),
        .pc_en_o      (pc_en),
        .PCsrc_o      (PCsrc),
        .immsrc_o     (immsrc),
        .ALUsrc_o     (ALUsrc),
        .ALUctrl_o    (ALUctrl),
        .resultsrc_o  (resultsrc),
        .regwr_o      (regwr),
        .halted_o     (halted),
        .bus_err_o    (bus_err),
        .retire_cnt_o (retire_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: where the instruction stream stands
    bit m_in_mem  = 1'b0;
    bit m_halted  = 1'b0;
    bit m_bus_err = 1'b0;
    int m_ret     = 0;
    int m_wait    = 0;   // MEM cycles already spent without ack

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic kind_t classify(input logic [31:0] w);
        logic [2:0] f3;
        bit         alu_ok;
        f3     = w[14:12];
        alu_ok = (f3 == 3'd0) || (f3 == 3'd6) || (f3 == 3'd7);
        case (w[6:0])
            7'b0110011: return alu_ok ? K_R : K_ILL;
            7'b0010011: return alu_ok ? K_I : K_ILL;
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b1100011: return (f3 <= 3'd1) ? K_BR : K_ILL;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            default:    return K_ILL;
        endcase
    endfunction

    // One clock: drive inputs after the edge, check before the next, advance model
    task automatic cycle(input logic r, input logic [31:0] ins, input logic z, input logic a);
        kind_t       k;
        logic [12:0] obs_v, msk;
        logic        e_pcen, e_rw, e_req, e_we, e_alus, rw_dec;
        logic [1:0]  e_pcs, e_imm, e_aluc, e_res, aluf;
        logic [2:0]  f3;
        bit          timeout;

        @(posedge clk);
        #1;
        rst               = r;
        instr             = ins;
        zero              = z;
        dmem_bus.dmem_ack = a;
        @(negedge clk);

        chk("halted",     32'(halted),     32'(m_halted));
        chk("bus_err",    32'(bus_err),    32'(m_bus_err));
        chk("retire_cnt", 32'(retire_cnt), 32'(m_ret));

        k      = classify(ins);
        f3     = ins[14:12];
        aluf   = (f3 == 3'd0) ? ((k == K_R && ins[30]) ? 2'd1 : 2'd0) :
                 (f3 == 3'd7) ? 2'd2 : 2'd3;
        e_pcen = 0; e_rw = 0; e_req = 0; e_we = 0; e_alus = 0; rw_dec = 0;
        e_pcs  = 0; e_imm = 0; e_aluc = 0; e_res = 0;
        msk    = '0;

        // Decode expectations that hold whenever the core is running
        case (k)
            K_R:    begin rw_dec = 1; e_aluc = aluf; msk = M_ALUS | M_RES | M_ALUC | M_PCS; end
            K_I:    begin rw_dec = 1; e_alus = 1; e_aluc = aluf;
                          msk = M_IMM | M_ALUS | M_RES | M_ALUC | M_PCS; end
            K_LW:   begin e_alus = 1; msk = M_IMM | M_ALUS | M_ALUC | M_PCS; end
            K_SW:   begin e_imm = 2'd1; e_alus = 1; msk = M_IMM | M_ALUS | M_ALUC | M_PCS; end
            K_BR:   begin e_imm = 2'd2; e_aluc = 2'd1;
                          e_pcs = (((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z)) ? 2'd1 : 2'd0;
                          msk = M_IMM | M_ALUS | M_ALUC | M_PCS; end
            K_JAL:  begin rw_dec = 1; e_imm = 2'd3; e_res = 2'd2; e_pcs = 2'd1;
                          msk = M_IMM | M_RES | M_PCS; end
            K_JALR: begin rw_dec = 1; e_alus = 1; e_res = 2'd2; e_pcs = 2'd2;
                          msk = M_IMM | M_ALUS | M_ALUC | M_RES | M_PCS; end
            default: ;
        endcase
        msk = msk | M_PCEN | M_RW | M_REQ | M_WE;

        timeout = 0;
        if (!r) begin
            msk = '1;
            e_pcen = 0; e_rw = 0; e_alus = 0; e_pcs = 0; e_imm = 0; e_aluc = 0; e_res = 0;
        end else if (m_halted) begin
            msk = M_PCEN | M_RW | M_REQ | M_WE;
        end else if (m_in_mem) begin
            e_req = 1;
            e_we  = (k == K_SW);
            if (a) begin
                e_pcen = 1;
                e_rw   = (k == K_LW);
                if (k == K_LW) begin
                    e_res = 2'd1;
                    msk   = msk | M_RES;
                end
            end
`ifdef DMEM_TIMEOUT_EN
            else begin
                timeout = (m_wait == TB_TO - 1);
            end
`endif
        end else if (k != K_ILL && k != K_LW && k != K_SW) begin
            e_pcen = 1;
            e_rw   = rw_dec;
        end

        obs_v = {pc_en, regwr, dmem_bus.dmem_req, dmem_bus.dmem_we,
                 PCsrc, immsrc, ALUsrc, ALUctrl, resultsrc};
        chk("controls", 32'(obs_v & msk),
            32'({e_pcen, e_rw, e_req, e_we, e_pcs, e_imm, e_alus, e_aluc, e_res} & msk));

        // Advance the model across the coming clock edge
        if (!r) begin
            m_in_mem = 0; m_halted = 0; m_bus_err = 0; m_ret = 0; m_wait = 0;
        end else if (m_halted) begin
        end else if (m_in_mem) begin
            if (a) begin
                m_ret    = (m_ret + 1) % CNT_MOD;
                m_in_mem = 0;
            end else if (timeout) begin
                m_halted  = 1;
                m_bus_err = 1;
                m_in_mem  = 0;
            end else begin
                m_wait++;
            end
        end else if (k == K_ILL) begin
            m_halted = 1;
        end else if (k == K_LW || k == K_SW) begin
            m_in_mem = 1;
            m_wait   = 0;
        end else begin
            m_ret = (m_ret + 1) % CNT_MOD;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [2:0]  alu_f3 [3];
        logic [6:0]  bad_op [4];
        int          p;
        alu_f3 = '{3'd0, 3'd6, 3'd7};
        bad_op = '{7'h7F, 7'h37, 7'h17, 7'h73};
        w = $urandom;
        p = $urandom_range(0, 99);
        if      (p < 20) begin w[6:0] = 7'b0110011; w[14:12] = alu_f3[$urandom_range(0, 2)]; end
        else if (p < 40) begin w[6:0] = 7'b0010011; w[14:12] = alu_f3[$urandom_range(0, 2)]; end
        else if (p < 52) w[6:0] = 7'b0000011;
        else if (p < 64) w[6:0] = 7'b0100011;
        else if (p < 78) begin w[6:0] = 7'b1100011; w[14:12] = 3'($urandom_range(0, 1)); end
        else if (p < 86) w[6:0] = 7'b1101111;
        else if (p < 94) w[6:0] = 7'b1100111;
        else if (p < 97) begin w[6:0] = (p == 94) ? 7'b1100011 : 7'b0010011; w[14:12] = 3'b010; end
        else w[6:0] = bad_op[$urandom_range(0, 3)];
        return w;
    endfunction

    initial begin
        logic [31:0] cur;
        logic        r;
        int          halt_run;

        rst = 1'b0; instr = 32'h13; zero = 1'b0; dmem_bus.dmem_ack = 1'b0;

        // Reset state
        cycle(0, 32'h13, 0, 0);
        cycle(0, I_ADDI, 1, 1);
        // addi retires in one cycle
        cycle(1, I_ADDI, 0, 0);
        // lw: three waiting MEM cycles, then ack
        cycle(1, I_LW, 0, 0);
        repeat (3) cycle(1, I_LW, 0, 0);
        cycle(1, I_LW, 0, 1);
        // beq taken / not taken, then jalr
        cycle(1, I_BEQ, 1, 0);
        cycle(1, I_BEQ, 0, 0);
        cycle(1, I_JALR, 0, 1);
        // reset in the middle of a store, with ack present in that cycle
        cycle(1, I_SW, 0, 0);
        cycle(1, I_SW, 0, 0);
        cycle(0, I_SW, 0, 1);
        cycle(1, I_ADDI, 0, 0);
        // illegal opcode: halt is sticky until reset
        cycle(1, I_BAD, 0, 0);
        repeat (11) cycle(1, I_ADDI, 1'($urandom), 1'($urandom));
        cycle(0, I_ADDI, 0, 0);
        cycle(1, I_ADDI, 0, 0);
        // store left without ack (times out only when the timeout is built in)
        cycle(1, I_SW, 0, 0);
        repeat (6) cycle(1, I_SW, 0, 0);
        cycle(1, I_SW, 0, 1);
        cycle(0, I_ADDI, 0, 0);

        // Randomized run
        cur      = I_ADDI;
        halt_run = 0;
        for (int i = 0; i < 3000; i++) begin
            if (m_halted) halt_run++;
            r = (halt_run <= 4) && ($urandom_range(0, 199) != 0);
            if (!r) halt_run = 0;
            if (!m_in_mem) cur = rand_instr();
            cycle(r, cur, 1'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
